// File: rtl/ball_plotter.sv
// Ball plotter: on each frame tick erases the previous SIZE x SIZE block with
//   BG_COLOUR, then draws the new block, one pixel per cycle into the VGA write port.
// Latency: first pixel two cycles after start; done at start+2+SIZE^2 (no erase)
//   or start+2+2*SIZE^2. start is ignored while busy (no queueing).
// Option macro: BALL_PLOTTER_SKIP_UNCHANGED_EN - an unchanged origin/colour skips
//   straight to done (two cycles after start) without plotting.
// Ports:
//   clock, resetn      - system clock, asynchronous active-low reset
//   start              - one-cycle redraw request
//   orig_x/orig_y      - block top-left corner; colour_in - block colour
//   x_out/y_out/colour_out/plot - registered pixel write to the VGA adapter
//   busy, done         - redraw in progress / one-cycle completion pulse
module ball_plotter #(
    parameter int         SIZE      = 4,
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter int         X_MAX     = 159,
    parameter int         Y_MAX     = 119
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] orig_x,
    input  logic [6:0] orig_y,
    input  logic [2:0] colour_in,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [2:0] LAST = 3'(SIZE - 1);

    state_t     state, state_nxt;
    logic [2:0] dx, dx_nxt;
    logic [2:0] dy, dy_nxt;

    // Values captured at start; the sweep never looks at the live inputs.
    logic [7:0] new_x;
    logic [6:0] new_y;
    logic [2:0] new_col;

    // Block currently on screen, remembered for the next erase.
    logic [7:0] old_x;
    logic [6:0] old_y;
    logic       old_valid;
`ifdef BALL_PLOTTER_SKIP_UNCHANGED_EN
    logic [2:0] old_col;
`endif

    logic       latch;
    logic       fin;
    logic [7:0] x_nxt;
    logic [6:0] y_nxt;
    logic [2:0] col_nxt;
    logic       plot_nxt;
    logic       busy_nxt;
    logic       done_nxt;

    // Sums are one bit wider than the screen coordinates so that a block
    // hanging off the right/bottom edge is clipped rather than wrapped.
    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       visible;

    assign base_x  = (state == ERASE) ? old_x : new_x;
    assign base_y  = (state == ERASE) ? old_y : new_y;
    assign sum_x   = {1'b0, base_x} + {6'b0, dx};
    assign sum_y   = {1'b0, base_y} + {5'b0, dy};
    assign visible = (sum_x <= 9'(X_MAX)) && (sum_y <= 8'(Y_MAX));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            dx    <= 3'd0;
            dy    <= 3'd0;
        end else begin
            state <= state_nxt;
            dx    <= dx_nxt;
            dy    <= dy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dx_nxt    = dx;
        dy_nxt    = dy;
        latch     = 1'b0;
        fin       = 1'b0;
        x_nxt     = x_out;
        y_nxt     = y_out;
        col_nxt   = colour_out;
        plot_nxt  = 1'b0;
        busy_nxt  = busy;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    latch    = 1'b1;
                    dx_nxt   = 3'd0;
                    dy_nxt   = 3'd0;
                    busy_nxt = 1'b1;
                    if (old_valid) state_nxt = ERASE;
                    else           state_nxt = DRAW;
`ifdef BALL_PLOTTER_SKIP_UNCHANGED_EN
                    if (old_valid && (orig_x == old_x) && (orig_y == old_y) &&
                        (colour_in == old_col))
                        state_nxt = FIN;
`endif
                end
            end

            ERASE, DRAW: begin
                // Clipped slots still take a cycle; they just do not plot.
                plot_nxt = visible;
                if (visible) begin
                    x_nxt   = sum_x[7:0];
                    y_nxt   = sum_y[6:0];
                    col_nxt = (state == ERASE) ? BG_COLOUR : new_col;
                end
                if (dx == LAST) begin
                    dx_nxt = 3'd0;
                    if (dy == LAST) begin
                        dy_nxt    = 3'd0;
                        state_nxt = (state == ERASE) ? DRAW : FIN;
                    end else begin
                        dy_nxt = dy + 3'd1;
                    end
                end else begin
                    dx_nxt = dx + 3'd1;
                end
            end

            FIN: begin
                fin       = 1'b1;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            new_x   <= 8'd0;
            new_y   <= 7'd0;
            new_col <= 3'd0;
        end else if (latch) begin
            new_x   <= orig_x;
            new_y   <= orig_y;
            new_col <= colour_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            old_x     <= 8'd0;
            old_y     <= 7'd0;
            old_valid <= 1'b0;
        end else if (fin) begin
            old_x     <= new_x;
            old_y     <= new_y;
            old_valid <= 1'b1;
        end
    end

`ifdef BALL_PLOTTER_SKIP_UNCHANGED_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)  old_col <= 3'd0;
        else if (fin) old_col <= new_col;
    end
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_out      <= 8'd0;
            y_out      <= 7'd0;
            colour_out <= 3'd0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            x_out      <= x_nxt;
            y_out      <= y_nxt;
            colour_out <= col_nxt;
            plot       <= plot_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_ball_plotter.sv
// Bench for ball_plotter: randomized redraw requests checked against a
//   pixel-list model of the erase/draw sweep, timing of done/busy, clipping and resets.
module tb_ball_plotter;

    localparam int         SIZE = 4;
    localparam logic [2:0] BG   = 3'b000;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] orig_x;
    logic [6:0] orig_y;
    logic [2:0] colour_in;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    // Model of what is on screen from the plotter's point of view.
    int         m_x     = 0;
    int         m_y     = 0;
    logic [2:0] m_col   = 3'b000;
    bit         m_valid = 1'b0;

    logic [17:0] exp_q[$];
    logic [17:0] got_q[$];

    ball_plotter dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .orig_x     (orig_x),
        .orig_y     (orig_y),
        .colour_in  (colour_in),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Append the visible pixels of one block, row by row, column fastest.
    task automatic model_sweep(input int bx, input int by, input logic [2:0] c);
        for (int yy = 0; yy < SIZE; yy++)
            for (int xx = 0; xx < SIZE; xx++)
                if (bx + xx <= 159 && by + yy <= 119)
                    exp_q.push_back({8'(bx + xx), 7'(by + yy), c});
    endtask

    task automatic run_redraw(input int x, input int y, input logic [2:0] col, input bit pulse);
        int  slots;
        int  exp_done;
        int  c;
        bit  seen;
        bit  skip;
        exp_q.delete();
        got_q.delete();
        skip = 1'b0;
`ifdef BALL_PLOTTER_SKIP_UNCHANGED_EN
        if (m_valid && x == m_x && y == m_y && col == m_col) skip = 1'b1;
`endif
        slots = 0;
        if (!skip) begin
            if (m_valid) begin
                model_sweep(m_x, m_y, BG);
                slots += SIZE * SIZE;
            end
            model_sweep(x, y, col);
            slots += SIZE * SIZE;
        end
        exp_done = skip ? 2 : 2 + slots;

        orig_x    = 8'(x);
        orig_y    = 7'(y);
        colour_in = col;
        start     = 1'b1;
        @(posedge clock); #1;
        start = pulse;
        c    = 0;
        seen = 1'b0;
        while (!seen && c < 200) begin
            @(negedge clock);
            c++;
            if (c == 1) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_after_start: got %b want 1", busy);
                end
            end
            if (plot) begin
                total++;
                if (x_out > 8'd159 || y_out > 7'd119) begin
                    bad++;
                    $display("FAIL offscreen_plot: got (%0d,%0d) want inside 159x119", x_out, y_out);
                end
                got_q.push_back({x_out, y_out, colour_out});
            end
            if (done) begin
                seen  = 1'b1;
                start = 1'b0;
            end else begin
                @(posedge clock); #1;
                // Inputs wander mid-redraw; only the values taken at start may matter.
                start     = pulse;
                orig_x    = 8'($urandom);
                orig_y    = 7'($urandom);
                colour_in = 3'($urandom);
            end
        end

        total++;
        if (!seen) begin
            bad++;
            $display("FAIL done_timeout: got no done after %0d cycles want done at %0d", c, exp_done);
        end else if (c != exp_done) begin
            bad++;
            $display("FAIL done_cycle: got %0d want %0d", c, exp_done);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_at_done: got %b want 0", busy);
        end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL plot_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL pixel_%0d: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)", i,
                         got_q[i][17:10], got_q[i][9:3], got_q[i][2:0],
                         exp_q[i][17:10], exp_q[i][9:3], exp_q[i][2:0]);
            end
        end

        m_x     = x;
        m_y     = y;
        m_col   = col;
        m_valid = 1'b1;

        // Quiet afterwards: one done only, no stray sequences.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            total++;
            if (plot !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_after_done: got plot=%b done=%b busy=%b want 0 0 0", plot, done, busy);
            end
        end
    endtask

    task automatic test_reset;
        resetn    = 1'b0;
        start     = 1'b0;
        orig_x    = 8'd0;
        orig_y    = 7'd0;
        colour_in = 3'd0;
        repeat (3) @(negedge clock);
        total++;
        if ({x_out, y_out, colour_out, plot, busy, done} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs: got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b want all 0",
                     x_out, y_out, colour_out, plot, busy, done);
        end
        resetn  = 1'b1;
        m_valid = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_first_draw;
        run_redraw(80, 10, 3'b100, 1'b0);
    endtask

    task automatic test_erase_draw;
        run_redraw(80, 14, 3'b010, 1'b0);
    endtask

    task automatic test_clipping;
        run_redraw(158, 118, 3'b111, 1'b0);
        run_redraw(157, 50, 3'b011, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_redraw(20, 30, 3'b101, 1'b1);
    endtask

    task automatic test_mid_reset;
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn  = 1'b1;
        m_valid = 1'b0;
        @(negedge clock);
        orig_x    = 8'd30;
        orig_y    = 7'd40;
        colour_in = 3'b110;
        start     = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        // Seventh cycle after acceptance: DRAW sweep sits at dx=2, dy=1.
        repeat (7) @(negedge clock);
        resetn = 1'b0;
        #1;
        total++;
        if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got plot=%b busy=%b done=%b want 0 0 0", plot, busy, done);
        end
        @(negedge clock);
        resetn  = 1'b1;
        m_valid = 1'b0;
        @(negedge clock);
        run_redraw(30, 40, 3'b110, 1'b0);
    endtask

    task automatic test_same_origin;
        run_redraw(60, 60, 3'b001, 1'b0);
        run_redraw(60, 60, 3'b001, 1'b0);
        run_redraw(60, 60, 3'b011, 1'b0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 12; n++)
            run_redraw(int'($urandom_range(0, 170)), int'($urandom_range(0, 127)),
                       3'($urandom), 1'($urandom));
    endtask

    initial begin
        test_reset();
        test_first_draw();
        test_erase_draw();
        test_clipping();
        test_back_to_back();
        test_mid_reset();
        test_same_origin();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ball_plotter.md
Name: ball_plotter

Overview:
- Downstream of the wheel/ball position counter; consumes its origin X/Y and 3-bit colour once per frame.
- On each frame tick, erases the previously drawn SIZE x SIZE block with background colour, then draws the new block.
- Emits one pixel per cycle (x, y, colour, plot strobe) straight into the VGA adapter write port (160x120, 3-bit colour).

Parameters:
- SIZE, 4, block edge length in pixels (1..8); offset counters are 3 bits wide.
- BG_COLOUR, 3'b000, colour used by the erase phase.
- X_MAX, 159, last visible column; pixels beyond it are clipped.
- Y_MAX, 119, last visible row; pixels beyond it are clipped.

Ports:
- clock  in  1  system clock (50 MHz domain).
- resetn  in  1  asynchronous reset, active-low.
- start  in  1  frame tick; one-cycle pulse requesting a redraw.
- orig_x  in  8  block origin column (top-left), from the position counter.
- orig_y  in  7  block origin row (top-left).
- colour_in  in  3  block colour.
- x_out  out  8  pixel column to VGA adapter.
- y_out  out  7  pixel row to VGA adapter.
- colour_out  out  3  pixel colour to VGA adapter.
- plot  out  1  VGA writeEn; pixel valid this cycle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of a redraw.

Behaviour:
- Reset (resetn=0, async): state=IDLE; x_out=0, y_out=0, colour_out=0, plot=0, busy=0, done=0; dx=dy=0; old_x=0, old_y=0, old_valid=0.
- States: IDLE, ERASE, DRAW, FIN.
- IDLE: start=1 latches new_x=orig_x, new_y=orig_y, new_col=colour_in; next state ERASE if old_valid=1, else DRAW; dx=dy=0. start=0 stays IDLE.
- ERASE: each cycle registers x_out=old_x+dx, y_out=old_y+dy, colour_out=BG_COLOUR, plot=1 (subject to clipping).
- DRAW: same sweep, using new_x/new_y/new_col.
- Sweep order: dx increments fastest; at dx=SIZE-1, dx->0 and dy++. At dx=dy=SIZE-1 the phase ends: ERASE->DRAW, DRAW->FIN, counters cleared.
- Outputs are registered: a pixel appears on the ports the cycle after its state/counter value. plot is 0 whenever no pixel is being emitted.
- Clipping: sum computed 1 bit wider (9-bit x, 8-bit y). If x>X_MAX or y>Y_MAX, plot=0 for that slot. The slot still consumes one cycle; coordinates never wrap onto the screen.
- FIN: old_x<=new_x, old_y<=new_y, old_valid<=1; done=1 for one cycle; busy falls the same cycle done rises; next state IDLE.
- Latency: start accepted in cycle N; first pixel visible N+2; done at N+2+2*SIZE^2 with old_valid, else N+2+SIZE^2.
- start while busy (ERASE/DRAW/FIN) is ignored, not queued.
- Origin/colour inputs changing mid-redraw have no effect; only the values latched at start are used.
- Reset mid-operation: immediate return to IDLE with plot=0. old_valid cleared, so the next redraw skips erase. The partially drawn block is left on screen by design.

Optional Feature:
- Macro: BALL_PLOTTER_SKIP_UNCHANGED_EN.
- Defined: in IDLE, if start=1, old_valid=1, and orig_x==old_x, orig_y==old_y, colour_in==old_col (old_col stored at FIN), go straight to FIN. No pixels are plotted; done is asserted 2 cycles after start.
- Undefined: every accepted start performs the full erase+draw sequence; old_col is not implemented.

Test Plan:
- Reset release, start with orig=(80,10), colour=3'b100 -> no erase; 16 plots at (80..83,10..13), colour 100, dx-fastest order; done once at start+18.
- Second start with orig=(80,14), colour=3'b010 -> 16 plots at (80..83,10..13) colour 000, then 16 at (80..83,14..17) colour 010; done at start+34.
- Origin (158,118), SIZE=4 -> only (158,118),(159,118),(158,119),(159,119) plotted; 16 draw cycles still elapse; no x_out>159 or y_out>119 while plot=1.
- start pulsed every cycle during a redraw -> exactly one done; no extra erase/draw sequences.
- resetn low during DRAW at dx=2,dy=1 -> plot=0 and busy=0 immediately; next start does draw only (16 plots).
- With BALL_PLOTTER_SKIP_UNCHANGED_EN, repeat the identical origin/colour -> zero plots, done 2 cycles after start; change colour only -> full 32-pixel sequence.
